vmem_access_seq: RTL and testbench
==================================

Name: vmem_access_seq

Overview:
- Vector load/store sequencer for the 3-port vector data memory (3 combinational read ports, 3 write ports sharing one write enable, word index = address[N-1:2]).
- Accepts one strided vector transaction from the vector core, splits it into beats of up to 3 elements, and drives the memory ports one beat per cycle.
- Gathers load data into a result vector; signals completion with a one-cycle done pulse.

Parameters:
- N, 18, data and byte-address width (matches memory).
- VLEN, 12, maximum elements per transaction.
- DEPTH, 1000, memory depth in words (used only by the optional bounds check).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_base  in  N  byte address of element 0.
- req_stride  in  N  byte stride between elements (two's complement, mod 2^N).
- req_len  in  $clog2(VLEN+1)  element count.
- wdata_vec  in  VLEN*N  store data; element i at [i*N +: N].
- rdata_vec  out  VLEN*N  load result; element i at [i*N +: N].
- busy  out  1  high in ISSUE and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  bounds error flag, valid with done.
- mem_oe, mem_we  out  1  memory OutputEnable / wEnable.
- mem_pos1..3  out  N  lane byte addresses.
- mem_wd1..3  out  N  lane write data.
- mem_rd1..3  in  N  lane read data.

Behaviour:
- FSM states: IDLE, ISSUE, DONE.
- Reset values: state=IDLE, rdata_vec=0, done=0, err=0, busy=0, mem_we=0, mem_oe=0, mem_pos*=0, mem_wd*=0.
- Memory strobes are decoded from the registered state, so an asserted rst_n drops mem_we at once, not at the next edge.
- Accept on req_valid && req_ready (IDLE only):
  - Latch request; store data is latched at accept, so later wdata_vec changes are ignored.
  - Clamp len to VLEN.
  - Zero rdata_vec; clear err.
  - len=0 goes to DONE; otherwise go to ISSUE with beat index 0.
- ISSUE, beat k, lanes j=0..2, element e=3k+j:
  - Lane address = base + e*stride mod 2^N, generated incrementally: beat base += 3*stride, lane offsets = 0, stride, 2*stride.
  - Partial last beat (e >= len): the unused lane replicates lane 0's address and data. This makes the extra write idempotent; for loads the lane result is discarded.
  - Load beat: mem_oe=1, mem_we=0; mem_rd_j is captured into element e at the clock edge closing the beat.
  - Store beat: mem_we=1, mem_oe=0, mem_wd_j = element e.
  - Last beat (3k+3 >= len) goes to DONE.
  - Number of beats = ceil(len/3).
- Address collisions within a beat (e.g. stride 0): the memory resolves lane 3 over lane 2 over lane 1, so the highest element index wins. This is the architected result.
- Address wrap-around mod 2^N is legal and unflagged.
- DONE lasts one cycle:
  - done=1; mem_we=mem_oe=0.
  - Then return to IDLE.
  - rdata_vec holds until the next accept.
- Latency: done asserts ceil(len/3)+1 cycles after the accept edge (1 cycle for len=0). Throughput is one transaction per ceil(len/3)+2 cycles.
- req_valid during ISSUE/DONE is ignored; the requester holds it until accepted.
- Reset mid-transaction aborts it. Beats already written remain in memory; no done pulse.

Optional Feature:
- Macro VMEM_BOUNDS_CHECK_EN.
- Defined: each beat checks the word index of every active lane against DEPTH.
  - On any index >= DEPTH, that beat asserts neither mem_we nor mem_oe.
  - The FSM jumps to DONE with err=1 held through the done pulse.
  - Earlier beats remain committed; rdata_vec keeps the elements captured so far.
- Undefined: no check; err is tied 0; out-of-range accesses are passed to the memory as-is.

Decomposition:
- Package vmem_pkg: LANES=3 constant, state enum (IDLE, ISSUE, DONE), default DEPTH.
- Sub-module vmem_addr_gen: holds the beat base, produces 3 lane addresses plus lane-valid mask from remaining length, and advances by 3*stride on step.

Test Plan:
- Load len=7, base=0x40, stride=4, words 16..22 preloaded with 0x100..0x106:
  - mem_pos1 = 0x40, 0x4C, 0x58 over 3 beats; beat 3 pos2 = pos3 = 0x58.
  - done 4 cycles after accept.
  - Elements 0..6 = 0x100..0x106; elements 7..11 = 0.
- Store len=5, base=0, stride=8, data i+1:
  - Words 0, 2, 4, 6, 8 = 1..5; word 10 unchanged.
  - Beat 2 lane 3 = (0x18, 4).
- Store len=3, base=0x10, stride=0, data 7, 8, 9: word 4 = 9 after one beat.
- Store len=0: no mem_we/mem_oe cycle; done the cycle after accept.
- Store len=12, rst_n pulsed low during beat 2:
  - mem_we falls asynchronously; no done.
  - req_ready=1 after release; beats 3-4 words untouched.
- Load base=0x3FFFC, stride=4, len=2: lanes 0x3FFFC, 0x00000.
  - With VMEM_BOUNDS_CHECK_EN, store base word 998, stride=4, len=6: beat 1 blocked, err=1 with done, no memory write.

Source files
------------

// File: rtl/vmem_pkg.sv
// ============================================================================
// Module  : vmem_pkg
// Brief   : Shared constants and FSM state type for the vector memory sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vmem_pkg;
   localparam int LANES         = 3;
   localparam int DEFAULT_DEPTH = 1000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/vmem_addr_gen.sv
// ============================================================================
// Module  : vmem_addr_gen
// Brief   : Beat base register and 3-lane strided address / lane-valid generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vmem_addr_gen
   import vmem_pkg::*;
#(
   parameter int N  = 18,
   parameter int EW = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_load,
   input  logic                      i_step,
   input  logic [N-1:0]              i_base,
   input  logic [N-1:0]              i_stride,
   input  logic [EW-1:0]             i_remain,
   output logic [LANES-1:0][N-1:0]   o_addr,
   output logic [LANES-1:0]          o_vld
);

   logic [N-1:0] r_beat_base;
   logic [N-1:0] w_stride2;
   logic [N-1:0] w_stride3;

   assign w_stride2 = {i_stride[N-2:0], 1'b0};
   assign w_stride3 = w_stride2 + i_stride;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_base <= '0;
      end else if (i_load) begin
         r_beat_base <= i_base;
      end else if (i_step) begin
         r_beat_base <= r_beat_base + w_stride3;
      end
   end

   assign o_vld[0] = i_remain > EW'(0);
   assign o_vld[1] = i_remain > EW'(1);
   assign o_vld[2] = i_remain > EW'(2);

   // Idle lanes mirror lane 0 so a replicated store rewrites the same word.
   assign o_addr[0] = r_beat_base;
   assign o_addr[1] = o_vld[1] ? (r_beat_base + i_stride)  : r_beat_base;
   assign o_addr[2] = o_vld[2] ? (r_beat_base + w_stride2) : r_beat_base;

endmodule

`default_nettype wire

// File: rtl/vmem_access_seq.sv
// ============================================================================
// Module  : vmem_access_seq
// Brief   : Strided vector load/store sequencer driving a 3-port data memory.
//           Optional word-index bounds check: define VMEM_BOUNDS_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vmem_access_seq
   import vmem_pkg::*;
#(
   parameter int N     = 18,
   parameter int VLEN  = 12,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_store,
   input  logic [N-1:0]                  req_base,
   input  logic [N-1:0]                  req_stride,
   input  logic [$clog2(VLEN+1)-1:0]     req_len,
   input  logic [VLEN*N-1:0]             wdata_vec,
   output logic [VLEN*N-1:0]             rdata_vec,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic                          mem_oe,
   output logic                          mem_we,
   output logic [N-1:0]                  mem_pos1,
   output logic [N-1:0]                  mem_pos2,
   output logic [N-1:0]                  mem_pos3,
   output logic [N-1:0]                  mem_wd1,
   output logic [N-1:0]                  mem_wd2,
   output logic [N-1:0]                  mem_wd3,
   input  logic [N-1:0]                  mem_rd1,
   input  logic [N-1:0]                  mem_rd2,
   input  logic [N-1:0]                  mem_rd3
);

   localparam int LW = $clog2(VLEN+1);
   localparam int EW = LW + 1;
   localparam int IW = $clog2(VLEN);

   state_t                   r_state;
   logic                     r_store;
   logic                     r_done;
   logic                     r_err;
   logic                     r_busy;
   logic [N-1:0]             r_stride;
   logic [LW-1:0]            r_len;
   logic [EW-1:0]            r_ebase;
   logic [N-1:0]             r_wdata [VLEN];
   logic [N-1:0]             r_rdata [VLEN];

   logic                     w_issue;
   logic                     w_last;
   logic                     w_blk;
   logic [LW-1:0]            w_len_clamp;
   logic [EW-1:0]            w_remain;
   logic [LANES-1:0][N-1:0]  w_addr;
   logic [LANES-1:0][N-1:0]  w_rd;
   logic [LANES-1:0][N-1:0]  w_wd;
   logic [LANES-1:0]         w_vld;
   logic [LANES-1:0]         w_oob;
   logic [IW-1:0]            w_eidx [LANES];

   assign w_issue     = (r_state == S_ISSUE);
   assign w_remain    = EW'(r_len) - r_ebase;
   assign w_last      = w_remain <= EW'(LANES);
   assign w_len_clamp = (req_len > LW'(VLEN)) ? LW'(VLEN) : req_len;
   assign w_rd        = {mem_rd3, mem_rd2, mem_rd1};

   vmem_addr_gen #(
      .N  (N),
      .EW (EW)
   ) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (req_valid && req_ready),
      .i_step   (w_issue),
      .i_base   (req_base),
      .i_stride (r_stride),
      .i_remain (w_remain),
      .o_addr   (w_addr),
      .o_vld    (w_vld)
   );

   generate
      for (genvar j = 0; j < LANES; j++) begin : g_lane
         assign w_eidx[j] = w_vld[j] ? IW'(r_ebase + EW'(j)) : IW'(r_ebase);
         assign w_wd[j]   = r_wdata[w_eidx[j]];
         assign w_oob[j]  = w_vld[j] && (32'(w_addr[j][N-1:2]) >= 32'(DEPTH));
      end
      for (genvar i = 0; i < VLEN; i++) begin : g_pack
         assign rdata_vec[i*N +: N] = r_rdata[i];
      end
   endgenerate

`ifdef VMEM_BOUNDS_CHECK_EN
   assign w_blk = w_issue && (|w_oob);
`else
   logic w_unused_oob;
   assign w_unused_oob = |w_oob;
   assign w_blk        = 1'b0;
`endif

   // Strobes decode the state register directly so reset kills them immediately.
   assign req_ready = (r_state == S_IDLE);
   assign mem_oe    = w_issue && !r_store && !w_blk;
   assign mem_we    = w_issue &&  r_store && !w_blk;
   assign mem_pos1  = w_issue ? w_addr[0] : '0;
   assign mem_pos2  = w_issue ? w_addr[1] : '0;
   assign mem_pos3  = w_issue ? w_addr[2] : '0;
   assign mem_wd1   = w_issue ? w_wd[0]   : '0;
   assign mem_wd2   = w_issue ? w_wd[1]   : '0;
   assign mem_wd3   = w_issue ? w_wd[2]   : '0;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_store  <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_stride <= '0;
         r_len    <= '0;
         r_ebase  <= '0;
         for (int i = 0; i < VLEN; i++) begin
            r_wdata[i] <= '0;
            r_rdata[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_store  <= req_store;
                  r_stride <= req_stride;
                  r_len    <= w_len_clamp;
                  r_ebase  <= '0;
                  r_err    <= 1'b0;
                  r_busy   <= 1'b1;
                  for (int i = 0; i < VLEN; i++) begin
                     r_wdata[i] <= wdata_vec[i*N +: N];
                     r_rdata[i] <= '0;
                  end
                  if (w_len_clamp == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (w_blk) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  if (!r_store) begin
                     for (int j = 0; j < LANES; j++) begin
                        if (w_vld[j]) r_rdata[w_eidx[j]] <= w_rd[j];
                     end
                  end
                  r_ebase <= r_ebase + EW'(LANES);
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vmem_access_seq.sv
// ============================================================================
// Module  : tb_vmem_access_seq
// Brief   : Self-checking bench for vmem_access_seq with a 3-port memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vmem_access_seq;
   localparam int N     = 18;
   localparam int VLEN  = 12;
   localparam int DEPTH = 1000;
   localparam int LW    = $clog2(VLEN+1);
`ifdef VMEM_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0, req_store = 1'b0;
   logic              req_ready, busy, done, err, mem_oe, mem_we;
   logic [N-1:0]      req_base = '0, req_stride = '0;
   logic [LW-1:0]     req_len = '0;
   logic [VLEN*N-1:0] wdata_vec = '0;
   logic [VLEN*N-1:0] rdata_vec;
   logic [N-1:0]      mem_pos1, mem_pos2, mem_pos3, mem_wd1, mem_wd2, mem_wd3;
   logic [N-1:0]      mem_rd1, mem_rd2, mem_rd3;

   always #5 clk = ~clk;

   vmem_access_seq #(.N(N), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_base(req_base), .req_stride(req_stride),
      .req_len(req_len), .wdata_vec(wdata_vec), .rdata_vec(rdata_vec),
      .busy(busy), .done(done), .err(err), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_pos1(mem_pos1), .mem_pos2(mem_pos2), .mem_pos3(mem_pos3),
      .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_wd3(mem_wd3),
      .mem_rd1(mem_rd1), .mem_rd2(mem_rd2), .mem_rd3(mem_rd3)
   );

   // Memory model: lane 3 beats lane 2 beats lane 1 on a shared word.
   logic [N-1:0] mem [65536];
   logic [N-1:0] ref_mem [65536];
   logic         pl_en = 1'b0;

   function automatic logic [N-1:0] pl_val(input int i);
      if (i >= 16 && i <= 22) return N'(32'h100 + i - 16);
      return N'((i * 37) ^ 32'h155);
   endfunction

   always @(posedge clk) begin
      if (pl_en) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pl_val(i);
      end else if (mem_we) begin
         mem[mem_pos1[N-1:2]] <= mem_wd1;
         mem[mem_pos2[N-1:2]] <= mem_wd2;
         mem[mem_pos3[N-1:2]] <= mem_wd3;
      end
   end

   assign mem_rd1 = mem[mem_pos1[N-1:2]];
   assign mem_rd2 = mem[mem_pos2[N-1:2]];
   assign mem_rd3 = mem[mem_pos3[N-1:2]];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   logic [N-1:0] tx_wd [VLEN];
   logic [N-1:0] ob_pos [8][3];
   logic [N-1:0] ob_wd  [8][3];
   int           ob_n;

   function automatic logic [N-1:0] eaddr(input logic [N-1:0] base, input logic [N-1:0] stride, input int e);
      return base + N'(e) * stride;
   endfunction

   task automatic mem_cmp(input string nm);
      int mis = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mis++;
      chk({nm, ":mem_mismatches"}, mis, 0);
   endtask

   task automatic run_txn(input bit st, input logic [N-1:0] base, input logic [N-1:0] stride,
                          input int len, input string nm);
      logic [N-1:0] exp_rd [VLEN];
      logic [N-1:0] a;
      int  L, nb, exec, cyc, mis, e;
      bit  eerr, bad, seen;
      L = (len > VLEN) ? VLEN : len;
      nb = (L + 2) / 3;
      eerr = 1'b0;
      exec = 0;
      for (int i = 0; i < VLEN; i++) exp_rd[i] = '0;
      for (int k = 0; k < nb && !eerr; k++) begin
         bad = 1'b0;
         for (int j = 0; j < 3; j++) begin
            e = 3*k + j;
            a = eaddr(base, stride, e);
            if (BC && e < L && int'(a[N-1:2]) >= DEPTH) bad = 1'b1;
         end
         if (bad) eerr = 1'b1;
         else begin
            exec++;
            for (int j = 0; j < 3; j++) begin
               e = 3*k + j;
               if (e < L) begin
                  a = eaddr(base, stride, e);
                  if (st) ref_mem[a[N-1:2]] = tx_wd[e];
                  else    exp_rd[e] = ref_mem[a[N-1:2]];
               end
            end
         end
      end

      @(negedge clk);
      chk({nm, ":ready"}, req_ready, 1);
      req_valid = 1'b1; req_store = st; req_base = base; req_stride = stride; req_len = LW'(len);
      for (int i = 0; i < VLEN; i++) wdata_vec[i*N +: N] = tx_wd[i];
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < VLEN; i++) wdata_vec[i*N +: N] = N'($urandom);

      ob_n = 0; seen = 1'b0; mis = 0;
      for (cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (mem_we || mem_oe) begin
            if (mem_we !== st || mem_oe !== !st) mis++;
            if (ob_n < 8) begin
               ob_pos[ob_n][0] = mem_pos1; ob_pos[ob_n][1] = mem_pos2; ob_pos[ob_n][2] = mem_pos3;
               ob_wd[ob_n][0]  = mem_wd1;  ob_wd[ob_n][1]  = mem_wd2;  ob_wd[ob_n][2]  = mem_wd3;
            end
            ob_n++;
         end
         if (done) begin seen = 1'b1; break; end
      end
      chk({nm, ":done_seen"}, seen, 1);
      chk({nm, ":done_latency"}, cyc, (eerr ? exec + 1 : nb) + 1);
      chk({nm, ":beats"}, ob_n, exec);
      chk({nm, ":err"}, err, eerr);
      chk({nm, ":busy_at_done"}, busy, 1);
      for (int k = 0; k < ob_n && k < 8; k++) begin
         for (int j = 0; j < 3; j++) begin
            e = (3*k + j < L) ? 3*k + j : 3*k;
            if (ob_pos[k][j] !== eaddr(base, stride, e)) mis++;
            if (st && ob_wd[k][j] !== tx_wd[e]) mis++;
         end
      end
      chk({nm, ":lane_mismatches"}, mis, 0);
      mis = 0;
      for (int i = 0; i < VLEN; i++) if (rdata_vec[i*N +: N] !== exp_rd[i]) mis++;
      chk({nm, ":rdata_mismatches"}, mis, 0);
      mem_cmp(nm);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = pl_val(i);
      pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
      @(negedge clk);
      chk("reset:ready", req_ready, 1);
      chk("reset:done", done, 0);
      chk("reset:busy", busy, 0);
      chk("reset:err", err, 0);
      chk("reset:we_oe", {mem_we, mem_oe}, 0);
      chk("reset:pos1", mem_pos1, 0);
      chk("reset:rdata_or", |rdata_vec, 0);
      rst_n = 1'b1;

      // Load len=7, base 0x40, stride 4 over preloaded words 16..22.
      for (int i = 0; i < VLEN; i++) tx_wd[i] = '0;
      run_txn(1'b0, 18'h40, 18'd4, 7, "load7");
      chk("load7:b0_pos1", ob_pos[0][0], 18'h40);
      chk("load7:b1_pos1", ob_pos[1][0], 18'h4C);
      chk("load7:b2_pos1", ob_pos[2][0], 18'h58);
      chk("load7:b2_pos2", ob_pos[2][1], 18'h58);
      chk("load7:b2_pos3", ob_pos[2][2], 18'h58);
      chk("load7:elem6", rdata_vec[6*N +: N], 18'h106);
      chk("load7:elem7", rdata_vec[7*N +: N], 0);

      for (int i = 0; i < VLEN; i++) tx_wd[i] = N'(i + 1);
      run_txn(1'b1, 18'h0, 18'd8, 5, "store5");
      chk("store5:b1_l3_pos", ob_pos[1][2], 18'h18);
      chk("store5:b1_l3_wd", ob_wd[1][2], 4);
      chk("store5:word8", mem[8], 5);
      chk("store5:word10", mem[10], pl_val(10));

      tx_wd[0] = 18'd7; tx_wd[1] = 18'd8; tx_wd[2] = 18'd9;
      run_txn(1'b1, 18'h10, 18'd0, 3, "stride0");
      chk("stride0:word4", mem[4], 9);

      run_txn(1'b1, 18'h80, 18'd4, 0, "len0");

      run_txn(1'b0, 18'h3FFFC, 18'd4, 2, "wrap");
`ifndef VMEM_BOUNDS_CHECK_EN
      chk("wrap:lane0", ob_pos[0][0], 18'h3FFFC);
      chk("wrap:lane1", ob_pos[0][1], 18'h0);
`else
      for (int i = 0; i < VLEN; i++) tx_wd[i] = N'($urandom);
      run_txn(1'b1, N'(998 * 4), 18'd4, 6, "bounds");
      chk("bounds:err", err, 1);
`endif

      // Reset in beat 2 of a 12-element store: only beat 1 lands.
      for (int i = 0; i < VLEN; i++) tx_wd[i] = N'($urandom);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_base = 18'h200; req_stride = 18'd4; req_len = LW'(12);
      for (int i = 0; i < VLEN; i++) wdata_vec[i*N +: N] = tx_wd[i];
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      chk("rst:we_before", mem_we, 1);
      rst_n = 1'b0;
      #1;
      chk("rst:we_async", mem_we, 0);
      chk("rst:busy", busy, 0);
      for (int e = 0; e < 3; e++) ref_mem[(18'h200 >> 2) + e] = tx_wd[e];
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int dn = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dn++;
         end
         chk("rst:no_done", dn, 0);
      end
      chk("rst:ready", req_ready, 1);
      mem_cmp("rst");

      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < VLEN; i++) tx_wd[i] = N'($urandom);
         run_txn(1'($urandom_range(0, 1)),
                 N'($urandom_range(0, 300) * 4 + $urandom_range(0, 3)),
                 N'(int'($urandom_range(0, 12)) * 4 - 16),
                 int'($urandom_range(0, 15)), $sformatf("rnd%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
